desc_kp_scheduler: RTL and testbench
====================================

Name: desc_kp_scheduler

Overview:
Keypoint sequencer for the descriptor engine (main orientation followed by local descriptor).
- Walks a keypoint-coordinate RAM and rejects keypoints inside the image border.
- Runs the engine once per accepted keypoint and supervises each run with a watchdog.
- Delivers each 1024-bit descriptor, tagged with its coordinate, over a valid/ready stream.
- Sits between the keypoint RAM / frame control and the descriptor engine.

Parameters:
KP_AW, 10, keypoint RAM address width
ROWS, 256, image height; row field is kp[17:8]
COLS, 256, image width; col field is kp[7:0]
BORDER, 10, border margin; keep iff BORDER<row<ROWS-BORDER and BORDER<col<COLS-BORDER
TIMEOUT, 65535, max RUN cycles before abort (16-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse; ignored unless idle
n_kp  in  KP_AW  number of keypoints; sampled on accepted start
kp_addr  out  KP_AW  keypoint RAM read address
kp_data  in  18  keypoint RAM data; synchronous read, 1-cycle latency
eng_run  out  1  engine enable; low holds the engine in reset
eng_kp  out  18  coordinate of the keypoint under processing
eng_done  in  1  engine descriptor-complete flag
eng_desc  in  1024  engine descriptor
desc_valid  out  1  descriptor output valid
desc_ready  in  1  downstream accept
desc_data  out  1024  registered descriptor
desc_kp  out  18  coordinate tag for desc_data
busy  out  1  high from accepted start through the DONE state
frame_done  out  1  one-cycle pulse at end of frame
cnt_desc  out  KP_AW  descriptors delivered this frame
cnt_skip  out  KP_AW  border rejects this frame
cnt_tmo  out  KP_AW  watchdog aborts this frame

Behaviour:
- Reset: every output and internal register is 0; state is IDLE.
- States: IDLE, FETCH, WAIT, CHECK, RUN, OUT, DONE.
- IDLE:
  - start=1 with n_kp=0: go to DONE.
  - start=1 otherwise: latch n_kp, clear idx and all counters, set busy, go to FETCH.
- FETCH: kp_addr=idx; go to WAIT.
- WAIT: register kp_data into eng_kp; go to CHECK.
- CHECK: apply the border test to eng_kp (strict compares).
  - Pass: go to RUN.
  - Fail: cnt_skip+1, then ADVANCE.
- RUN: eng_run=1 and the 16-bit watchdog counts up from 0.
  - eng_done=1: capture eng_desc into desc_data and eng_kp into desc_kp; go to OUT. eng_run is low from the next cycle.
  - Watchdog reaches TIMEOUT with eng_done=0: eng_run drops, cnt_tmo+1, ADVANCE, no output.
  - eng_done and timeout in the same cycle: done wins.
- OUT: eng_run=0 and desc_valid=1; desc_data and desc_kp are stable while valid.
  - desc_ready=1: cnt_desc+1, then ADVANCE.
  - Backpressure is unbounded; there is no timeout in OUT.
- ADVANCE (transition, not a state): idx==n_kp-1 goes to DONE; otherwise idx+1 and go to FETCH.
- DONE: frame_done=1 for exactly one cycle, busy=0 next cycle, go to IDLE.
- Engine reset gap: eng_run is low for at least 3 cycles between consecutive runs (OUT or abort, then FETCH, WAIT, CHECK), so the engine always starts from reset.
- Latency: start accepted at cycle 0 → kp_addr=0 in cycle 1 → eng_run=1 in cycle 4 for an in-border keypoint.
- Event filtering:
  - eng_done outside RUN is ignored.
  - start while busy is ignored.
  - n_kp changes after start have no effect.
- Counters: saturate at all-ones; hold their values after DONE until the next accepted start.
- Async reset mid-frame: immediate return to IDLE with all outputs 0. A pending descriptor is dropped and eng_run drops at once.

Test Plan:
1. n_kp=3, all coords 0x08080 (row 128, col 128), eng_done 20 cycles after each eng_run rise, desc_ready=1 → 3 descriptors with desc_kp=0x08080; cnt_desc=3, cnt_skip=0; frame_done exactly once; eng_run low ≥3 cycles between runs.
2. Border cases, n_kp=4, coords row/col (10,128), (11,128), (128,246), (128,245) → only the 2nd and 4th run the engine; cnt_skip=2, cnt_desc=2.
3. Backpressure: desc_ready held 0 for 50 cycles → desc_valid stays high, desc_data/desc_kp constant, eng_run=0, kp_addr unchanged; ready=1 for one cycle → one transfer, idx advances.
4. Timeout with TIMEOUT=100, eng_done never asserted → eng_run high exactly 100 cycles, cnt_tmo=1, no desc_valid; then next keypoint fetched. Repeat with eng_done on the 100th cycle → descriptor is output, cnt_tmo=0.
5. n_kp=0 start → frame_done in cycle 1, eng_run never high; start pulse while busy → no restart and counters unchanged.
6. rst low during RUN, and again during OUT → all outputs 0 asynchronously; after release, a new start processes the frame from idx 0.

Source files
------------

// File: rtl/desc_kp_scheduler_if.sv
// Bundles the keypoint RAM, engine, descriptor stream, frame-control and status signals.
interface desc_kp_scheduler_if #(
  parameter int unsigned KP_AW = 10
);
  logic             start;
  logic [KP_AW-1:0] n_kp;
  logic [KP_AW-1:0] kp_addr;
  logic [17:0]      kp_data;
  logic             eng_run;
  logic [17:0]      eng_kp;
  logic             eng_done;
  logic [1023:0]    eng_desc;
  logic             desc_valid;
  logic             desc_ready;
  logic [1023:0]    desc_data;
  logic [17:0]      desc_kp;
  logic             busy;
  logic             frame_done;
  logic [KP_AW-1:0] cnt_desc;
  logic [KP_AW-1:0] cnt_skip;
  logic [KP_AW-1:0] cnt_tmo;

  // Scheduler side.
  modport slave (
    input  start, n_kp, kp_data, eng_done, eng_desc, desc_ready,
    output kp_addr, eng_run, eng_kp, desc_valid, desc_data, desc_kp,
           busy, frame_done, cnt_desc, cnt_skip, cnt_tmo
  );

  // Frame control / RAM / engine / sink side.
  modport master (
    output start, n_kp, kp_data, eng_done, eng_desc, desc_ready,
    input  kp_addr, eng_run, eng_kp, desc_valid, desc_data, desc_kp,
           busy, frame_done, cnt_desc, cnt_skip, cnt_tmo
  );
endinterface

// File: rtl/desc_kp_scheduler.sv
// Keypoint sequencer: fetches coordinates, rejects border keypoints, runs the
// descriptor engine under a watchdog and streams out tagged descriptors.
module desc_kp_scheduler #(
  parameter int unsigned KP_AW   = 10,
  parameter int unsigned ROWS    = 256,
  parameter int unsigned COLS    = 256,
  parameter int unsigned BORDER  = 10,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  desc_kp_scheduler_if.slave   io_bus
);

  localparam int unsigned KP_W   = 18;
  localparam int unsigned DESC_W = 1024;
  localparam int unsigned WD_W   = 16;
  localparam logic [9:0]      ROW_LO  = 10'(BORDER);
  localparam logic [9:0]      ROW_HI  = 10'(ROWS - BORDER);
  localparam logic [7:0]      COL_LO  = 8'(BORDER);
  localparam logic [7:0]      COL_HI  = 8'(COLS - BORDER);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_RUN, S_OUT, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [KP_AW-1:0]    r_n_kp, w_n_kp_nxt;
  logic [KP_AW-1:0]    r_idx, w_idx_nxt;
  logic [KP_AW-1:0]    r_kp_addr, w_kp_addr_nxt;
  logic                r_eng_run, w_eng_run_nxt;
  logic [KP_W-1:0]     r_eng_kp, w_eng_kp_nxt;
  logic [WD_W-1:0]     r_wd, w_wd_nxt;
  logic                r_desc_valid, w_desc_valid_nxt;
  logic [DESC_W-1:0]   r_desc_data, w_desc_data_nxt;
  logic [KP_W-1:0]     r_desc_kp, w_desc_kp_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic [KP_AW-1:0]    r_cnt_desc, w_cnt_desc_nxt;
  logic [KP_AW-1:0]    r_cnt_skip, w_cnt_skip_nxt;
  logic [KP_AW-1:0]    r_cnt_tmo, w_cnt_tmo_nxt;

  logic                w_last;
  logic                w_in_border;
  logic                w_wd_tmo;
  logic [KP_AW-1:0]    w_idx_adv;
  logic [9:0]          w_row;
  logic [7:0]          w_col;

  function automatic logic [KP_AW-1:0] sat_inc(input logic [KP_AW-1:0] v);
    return (v == '1) ? v : v + KP_AW'(1);
  endfunction

  assign w_row       = r_eng_kp[17:8];
  assign w_col       = r_eng_kp[7:0];
  assign w_in_border = (w_row > ROW_LO) && (w_row < ROW_HI) &&
                       (w_col > COL_LO) && (w_col < COL_HI);
  assign w_last      = (r_idx == r_n_kp - KP_AW'(1));
  assign w_idx_adv   = w_last ? r_idx : r_idx + KP_AW'(1);
  assign w_wd_tmo    = (r_wd == WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; "advance" means DONE after the last keypoint, else FETCH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_nxt = (io_bus.n_kp == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_in_border ? S_RUN : (w_last ? S_DONE : S_FETCH);
      S_RUN: begin
        if (io_bus.eng_done) w_state_nxt = S_OUT;
        else if (w_wd_tmo)   w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_OUT:   if (io_bus.desc_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of datapath registers and registered outputs.
  always_comb begin
    w_n_kp_nxt      = r_n_kp;
    w_idx_nxt       = r_idx;
    w_eng_kp_nxt    = r_eng_kp;
    w_wd_nxt        = '0;
    w_desc_data_nxt = r_desc_data;
    w_desc_kp_nxt   = r_desc_kp;
    w_cnt_desc_nxt  = r_cnt_desc;
    w_cnt_skip_nxt  = r_cnt_skip;
    w_cnt_tmo_nxt   = r_cnt_tmo;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start && (io_bus.n_kp != '0)) begin
          w_n_kp_nxt     = io_bus.n_kp;
          w_idx_nxt      = '0;
          w_cnt_desc_nxt = '0;
          w_cnt_skip_nxt = '0;
          w_cnt_tmo_nxt  = '0;
        end
      end
      S_WAIT: w_eng_kp_nxt = io_bus.kp_data;
      S_CHECK: begin
        if (!w_in_border) begin
          w_cnt_skip_nxt = sat_inc(r_cnt_skip);
          w_idx_nxt      = w_idx_adv;
        end
      end
      S_RUN: begin
        // A done flag coinciding with the last watchdog cycle still delivers.
        if (io_bus.eng_done) begin
          w_desc_data_nxt = io_bus.eng_desc;
          w_desc_kp_nxt   = r_eng_kp;
        end else if (w_wd_tmo) begin
          w_cnt_tmo_nxt = sat_inc(r_cnt_tmo);
          w_idx_nxt     = w_idx_adv;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      S_OUT: begin
        if (io_bus.desc_ready) begin
          w_cnt_desc_nxt = sat_inc(r_cnt_desc);
          w_idx_nxt      = w_idx_adv;
        end
      end
      default: ;
    endcase
    w_kp_addr_nxt    = (w_state_nxt == S_FETCH) ? w_idx_nxt : r_kp_addr;
    w_eng_run_nxt    = (w_state_nxt == S_RUN);
    w_desc_valid_nxt = (w_state_nxt == S_OUT);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_frame_done_nxt = (w_state_nxt == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n_kp       <= '0;
      r_idx        <= '0;
      r_kp_addr    <= '0;
      r_eng_run    <= 1'b0;
      r_eng_kp     <= '0;
      r_wd         <= '0;
      r_desc_valid <= 1'b0;
      r_desc_data  <= '0;
      r_desc_kp    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cnt_desc   <= '0;
      r_cnt_skip   <= '0;
      r_cnt_tmo    <= '0;
    end else begin
      r_n_kp       <= w_n_kp_nxt;
      r_idx        <= w_idx_nxt;
      r_kp_addr    <= w_kp_addr_nxt;
      r_eng_run    <= w_eng_run_nxt;
      r_eng_kp     <= w_eng_kp_nxt;
      r_wd         <= w_wd_nxt;
      r_desc_valid <= w_desc_valid_nxt;
      r_desc_data  <= w_desc_data_nxt;
      r_desc_kp    <= w_desc_kp_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_cnt_desc   <= w_cnt_desc_nxt;
      r_cnt_skip   <= w_cnt_skip_nxt;
      r_cnt_tmo    <= w_cnt_tmo_nxt;
    end
  end

  assign io_bus.kp_addr    = r_kp_addr;
  assign io_bus.eng_run    = r_eng_run;
  assign io_bus.eng_kp     = r_eng_kp;
  assign io_bus.desc_valid = r_desc_valid;
  assign io_bus.desc_data  = r_desc_data;
  assign io_bus.desc_kp    = r_desc_kp;
  assign io_bus.busy       = r_busy;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.cnt_desc   = r_cnt_desc;
  assign io_bus.cnt_skip   = r_cnt_skip;
  assign io_bus.cnt_tmo    = r_cnt_tmo;

endmodule

// File: tb/tb_desc_kp_scheduler.sv
// Directed plus randomized bench for desc_kp_scheduler against a frame-level model.
module tb_desc_kp_scheduler;
  localparam int KP_AW  = 10;
  localparam int TMO    = 100;
  localparam int ROWS   = 256;
  localparam int COLS   = 256;
  localparam int BORDER = 10;

  logic clk;
  logic rst;
  desc_kp_scheduler_if #(.KP_AW(KP_AW)) bus();

  desc_kp_scheduler #(.KP_AW(KP_AW), .ROWS(ROWS), .COLS(COLS), .BORDER(BORDER), .TIMEOUT(TMO))
    dut (.clk(clk), .rst(rst), .io_bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0]   ram     [0:1023];
  int            lat_arr [0:1023];
  int            eng_cnt;
  logic          noise_done;
  logic [31:0]   noise32;
  logic [31:0]   frame_seed;
  int            checks, errors;
  logic [17:0]   got_kp[$];
  logic [1023:0] got_desc[$];
  int            fd_cnt, run_cnt;
  int            prev_desc, prev_skip, prev_tmo;

  function automatic logic [1023:0] make_desc(input logic [31:0] s, input logic [9:0] idx);
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = s ^ (32'(idx) * 32'h9E3779B9) ^ (32'(k) << 8);
    return r;
  endfunction

  function automatic bit in_border(input logic [17:0] kp);
    int r, c;
    r = int'(kp[17:8]);
    c = int'(kp[7:0]);
    return (r > BORDER) && (r < ROWS - BORDER) && (c > BORDER) && (c < COLS - BORDER);
  endfunction

  function automatic logic [17:0] mk_kp(input int r, input int c);
    return {10'(r), 8'(c)};
  endfunction

  // Synchronous-read keypoint RAM and a behavioural engine with per-keypoint latency.
  always @(posedge clk) bus.kp_data <= ram[bus.kp_addr];
  always @(posedge clk or negedge rst)
    if (!rst) eng_cnt <= 0;
    else      eng_cnt <= bus.eng_run ? eng_cnt + 1 : 0;
  always @(posedge clk) begin
    noise_done <= ($urandom_range(0, 3) == 0);
    noise32    <= $urandom;
  end
  assign bus.eng_done = bus.eng_run ? (eng_cnt == lat_arr[bus.kp_addr]) : noise_done;
  assign bus.eng_desc = bus.eng_run ? make_desc(frame_seed, bus.kp_addr) : {32{noise32}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed_lo=%0h expected_lo=%0h diff_bits=%0d",
             tag, obs[95:0], exp[95:0], $countones(obs ^ exp));
    end
  endtask

  // Stream/engine protocol monitor: run lengths, reset gaps, stability under backpressure.
  initial begin : mon
    int run_len, run_exp, gap;
    bit have_prev;
    logic [1023:0] p_data;
    logic [17:0] p_kp;
    logic [9:0] p_addr;
    run_len = 0; run_exp = 0; gap = 100; have_prev = 0;
    p_data = '0; p_kp = '0; p_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_len = 0; gap = 100; have_prev = 0;
      end else begin
        if (bus.eng_run) begin
          if (run_len == 0) begin
            chk("eng_gap_ge3", 64'(gap >= 3), 64'(1));
            run_cnt++;
            run_exp = (lat_arr[bus.kp_addr] < TMO) ? lat_arr[bus.kp_addr] + 1 : TMO;
          end
          run_len++;
          gap = 0;
        end else begin
          if (run_len != 0) chk("run_len", 64'(run_len), 64'(run_exp));
          run_len = 0;
          gap++;
        end
        if (bus.desc_valid) begin
          chk("valid_eng_run_low", 64'(bus.eng_run), 64'(0));
          if (have_prev) begin
            chk_wide("stable_desc_data", bus.desc_data, p_data);
            chk("stable_desc_kp", 64'(bus.desc_kp), 64'(p_kp));
            chk("stable_kp_addr", 64'(bus.kp_addr), 64'(p_addr));
          end
          if (bus.desc_ready) begin
            got_kp.push_back(bus.desc_kp);
            got_desc.push_back(bus.desc_data);
            have_prev = 0;
          end else begin
            have_prev = 1;
            p_data = bus.desc_data; p_kp = bus.desc_kp; p_addr = bus.kp_addr;
          end
        end else begin
          have_prev = 0;
        end
        if (bus.frame_done) fd_cnt++;
      end
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_kp_addr"}, 64'(bus.kp_addr), 64'(0));
    chk({pfx, "_eng_run"}, 64'(bus.eng_run), 64'(0));
    chk({pfx, "_eng_kp"}, 64'(bus.eng_kp), 64'(0));
    chk({pfx, "_desc_valid"}, 64'(bus.desc_valid), 64'(0));
    chk_wide({pfx, "_desc_data"}, bus.desc_data, '0);
    chk({pfx, "_desc_kp"}, 64'(bus.desc_kp), 64'(0));
    chk({pfx, "_busy"}, 64'(bus.busy), 64'(0));
    chk({pfx, "_frame_done"}, 64'(bus.frame_done), 64'(0));
    chk({pfx, "_cnts"}, 64'({bus.cnt_desc, bus.cnt_skip, bus.cnt_tmo}), 64'(0));
  endtask

  // One frame over ram[0..n-1] / lat_arr; rmode 0: ready=1, 1: random, 2: 50-cycle holds.
  task automatic run_frame(input int n, input int rmode, input bit chk_lat);
    int e_desc, e_skip, e_tmo, e_runs, c, first_run, fd_cycle, bp;
    bit done;
    logic [17:0] ekp[$];
    logic [1023:0] edesc[$];
    frame_seed = $urandom;
    got_kp.delete(); got_desc.delete();
    fd_cnt = 0; run_cnt = 0;
    e_desc = 0; e_skip = 0; e_tmo = 0; e_runs = 0;
    for (int i = 0; i < n; i++) begin
      if (!in_border(ram[i])) e_skip++;
      else begin
        e_runs++;
        if (lat_arr[i] < TMO) begin
          e_desc++;
          ekp.push_back(ram[i]);
          edesc.push_back(make_desc(frame_seed, 10'(i)));
        end else e_tmo++;
      end
    end
    if (n == 0) begin e_desc = prev_desc; e_skip = prev_skip; e_tmo = prev_tmo; end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.n_kp = KP_AW'(n); bus.desc_ready = (rmode == 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.n_kp = KP_AW'($urandom);
    c = 1; first_run = -1; fd_cycle = -1; bp = 0; done = 0;
    while (!done && c < 20000) begin
      bus.start = 1'b0;
      if (bus.eng_run && first_run < 0) first_run = c;
      if (bus.frame_done) begin
        done = 1; fd_cycle = c;
        chk("busy_in_done", 64'(bus.busy), 64'(1));
      end else begin
        case (rmode)
          0: bus.desc_ready = 1'b1;
          1: bus.desc_ready = 1'($urandom_range(0, 1));
          default: begin
            if (bus.desc_valid) begin
              bp++;
              bus.desc_ready = (bp > 50);
              if (bp > 50) bp = 0;
            end else bus.desc_ready = 1'b0;
          end
        endcase
        if (bus.busy && $urandom_range(0, 15) == 0) begin
          bus.start = 1'b1; bus.n_kp = KP_AW'($urandom);
        end
        c++;
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    chk("frame_done_seen", 64'(done), 64'(1));
    if (chk_lat && n > 0 && in_border(ram[0])) chk("first_run_cycle", 64'(first_run), 64'(4));
    if (n == 0) chk("done_cycle_nkp0", 64'(fd_cycle), 64'(1));
    bus.desc_ready = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_done", 64'(bus.busy), 64'(0));
    chk("frame_done_pulse", 64'(bus.frame_done), 64'(0));
    chk("frame_done_count", 64'(fd_cnt), 64'(1));
    chk("engine_runs", 64'(run_cnt), 64'(e_runs));
    chk("cnt_desc", 64'(bus.cnt_desc), 64'(e_desc));
    chk("cnt_skip", 64'(bus.cnt_skip), 64'(e_skip));
    chk("cnt_tmo", 64'(bus.cnt_tmo), 64'(e_tmo));
    chk("desc_count", 64'(got_kp.size()), 64'(ekp.size()));
    for (int i = 0; i < ekp.size() && i < got_kp.size(); i++) begin
      chk("desc_kp_tag", 64'(got_kp[i]), 64'(ekp[i]));
      chk_wide("desc_payload", got_desc[i], edesc[i]);
    end
    prev_desc = e_desc; prev_skip = e_skip; prev_tmo = e_tmo;
  endtask

  // Starts a two-keypoint frame and pulls reset once it reaches RUN or OUT.
  task automatic reset_mid(input bit in_out);
    int c;
    bit hit;
    frame_seed = $urandom;
    ram[0] = mk_kp(128, 128); lat_arr[0] = 20;
    ram[1] = mk_kp(100, 200); lat_arr[1] = 20;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.n_kp = KP_AW'(2); bus.desc_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 0; hit = 0;
    while (!hit && c < 200) begin
      hit = in_out ? (bus.desc_valid === 1'b1) : (bus.eng_run === 1'b1);
      if (!hit) begin c++; @(posedge clk); #1; end
    end
    chk(in_out ? "reach_out" : "reach_run", 64'(hit), 64'(1));
    if (in_out) repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero(in_out ? "rst_out" : "rst_run");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    prev_desc = 0; prev_skip = 0; prev_tmo = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0; errors = 0; fd_cnt = 0; run_cnt = 0;
    prev_desc = 0; prev_skip = 0; prev_tmo = 0;
    frame_seed = 32'h1234_5678;
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; lat_arr[i] = 0; end
    rst = 1'b0;
    bus.start = 1'b0; bus.n_kp = '0; bus.desc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Three centre keypoints, engine done 20 cycles after each run start.
    for (int i = 0; i < 3; i++) begin ram[i] = 18'h08080; lat_arr[i] = 20; end
    run_frame(3, 0, 1'b1);

    // Border boundaries: only the 2nd and 4th keypoints are inside.
    ram[0] = mk_kp(10, 128); ram[1] = mk_kp(11, 128);
    ram[2] = mk_kp(128, 246); ram[3] = mk_kp(128, 245);
    for (int i = 0; i < 4; i++) lat_arr[i] = 20;
    run_frame(4, 0, 1'b1);

    // Long backpressure on every descriptor.
    ram[0] = mk_kp(50, 60); ram[1] = mk_kp(200, 30);
    lat_arr[0] = 7; lat_arr[1] = 3;
    run_frame(2, 2, 1'b1);

    // Watchdog abort then a normal keypoint; then done on the final watchdog cycle.
    ram[0] = mk_kp(128, 128); lat_arr[0] = 1000;
    ram[1] = mk_kp(129, 127); lat_arr[1] = 5;
    run_frame(2, 0, 1'b1);
    ram[0] = mk_kp(77, 177); lat_arr[0] = TMO - 1;
    run_frame(1, 0, 1'b1);

    // Empty frame: counters from the previous frame must hold.
    run_frame(0, 0, 1'b0);

    // Asynchronous reset in RUN and in OUT, each followed by a clean frame.
    reset_mid(1'b0);
    ram[0] = mk_kp(20, 20); lat_arr[0] = 4;
    run_frame(1, 0, 1'b1);
    reset_mid(1'b1);
    ram[0] = mk_kp(30, 40); ram[1] = mk_kp(5, 40); lat_arr[0] = 9; lat_arr[1] = 9;
    run_frame(2, 0, 1'b1);

    // Randomized frames with random coordinates, latencies and backpressure.
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        int r, c;
        case ($urandom_range(0, 5))
          0: r = $urandom_range(0, 1023);
          1: r = 10;
          2: r = 11;
          3: r = 245;
          4: r = 246;
          default: r = $urandom_range(11, 245);
        endcase
        case ($urandom_range(0, 5))
          0: c = $urandom_range(0, 255);
          1: c = 10;
          2: c = 11;
          3: c = 245;
          4: c = 246;
          default: c = $urandom_range(11, 245);
        endcase
        ram[i] = mk_kp(r, c);
        case ($urandom_range(0, 6))
          0: lat_arr[i] = TMO - 1;
          1: lat_arr[i] = TMO;
          2: lat_arr[i] = 0;
          3: lat_arr[i] = 300;
          default: lat_arr[i] = $urandom_range(1, 40);
        endcase
      end
      run_frame(n, 1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
